// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-word layout, step indices and default step table
// Purpose: constants shared by the sequence controller and the blocks around it.
// Control word layout, MSB to LSB: {selA, wrA, wrB, aluOp[ALU_OP_W-1:0]}.
// The *_OFS constants are bit offsets above the aluOp field, so they hold for any ALU_OP_W.
package ctrl_pkg;

    localparam int ALUOP_LSB  = 0;
    localparam int WR_B_OFS   = 0;
    localparam int WR_A_OFS   = 1;
    localparam int SEL_A_OFS  = 2;
    localparam int CTRL_FLAGS = 3;

    // Absolute bit positions for the default 2-bit aluOp.
    localparam int WR_B_BIT  = 2 + WR_B_OFS;
    localparam int WR_A_BIT  = 2 + WR_A_OFS;
    localparam int SEL_A_BIT = 2 + SEL_A_OFS;

    localparam int IDLE      = 0;
    localparam int LOAD      = 1;
    localparam int DISPLAY_B = 2;
    localparam int STORE_Q   = 3;
    localparam int STORE_R   = 4;

    localparam int DEFAULT_N_STEPS  = 5;
    localparam int DEFAULT_ALU_OP_W = 2;

    // Step 0 in the LSBs: idle, load, displayB, storeQ, storeR.
    localparam logic [24:0] DEFAULT_STEP_TABLE = 25'b01011_01010_00001_11100_00000;

endpackage

// File: rtl/edge_detect_neg.sv
// rtl/edge_detect_neg.sv - rising-edge detector for a level input, sampled on negedge clock
// Ports: clock, reset (async, active-high), sig (level in), rise (sig high now, low last cycle).
// The history flop resets to 1 so an input already high at reset release is not seen as an edge.
module edge_detect_neg (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/seq_controle.sv
// rtl/seq_controle.sv - table-driven step sequencer for the register/ALU datapath
// Purpose: walks STEP_TABLE on dv rising edges or, in auto mode, after HOLD_CYCLES clocks per step.
// Ports: clock, reset (async, active-high), dv, auto_en, abort in;
//        selA, wrA, wrB, aluOp (control word), busy, done, prStateLed, nxStateLed out.
// All state updates on the falling edge of clock.
module seq_controle
    import ctrl_pkg::*;
#(
    parameter int N_STEPS  = 5,
    parameter int ALU_OP_W = 2,
    parameter int STEP_W   = $clog2(N_STEPS),
    parameter logic [N_STEPS*(3+ALU_OP_W)-1:0] STEP_TABLE = DEFAULT_STEP_TABLE,
    parameter int HOLD_CYCLES = 8,
    parameter int WR_PULSE    = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dv,
    input  logic                auto_en,
    input  logic                abort,
    output logic                selA,
    output logic                wrA,
    output logic                wrB,
    output logic [ALU_OP_W-1:0] aluOp,
    output logic                busy,
    output logic                done,
    output logic [STEP_W-1:0]   prStateLed,
    output logic [STEP_W-1:0]   nxStateLed
);

    localparam int CW_W = CTRL_FLAGS + ALU_OP_W;
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
    localparam logic [STEP_W-1:0] IDLE_STEP = STEP_W'(IDLE);
    localparam logic [HC_W-1:0]   HOLD_MAX  = HC_W'(HOLD_CYCLES - 1);

    logic [STEP_W-1:0] step, step_next;
    logic [HC_W-1:0]   hold_cnt, hold_cnt_next;
    logic              first;
    logic              dv_rise;
    logic              hold_hit;
    logic              advance;
    logic              wrap;
    logic [CW_W-1:0]   ctrl_word;

    edge_detect_neg u_dv_edge (
        .clock (clock),
        .reset (reset),
        .sig   (dv),
        .rise  (dv_rise)
    );

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            step     <= IDLE_STEP;
            hold_cnt <= '0;
            first    <= 1'b1;
            done     <= 1'b0;
        end else begin
            step     <= step_next;
            hold_cnt <= hold_cnt_next;
            first    <= (step_next != step);
            done     <= wrap;
        end
    end

    always_comb begin
        hold_hit      = 1'b0;
        advance       = 1'b0;
        wrap          = 1'b0;
        step_next     = step;
        hold_cnt_next = hold_cnt;

        // Step 0 is never timed out; it waits for the operator.
        hold_hit = auto_en && (step != IDLE_STEP) && (hold_cnt == HOLD_MAX);
        advance  = dv_rise || hold_hit;

        if (abort) begin
            step_next = IDLE_STEP;
        end else if (advance) begin
            step_next = (step == LAST_STEP) ? IDLE_STEP : step + 1'b1;
            wrap      = (step == LAST_STEP);
        end

        if ((step_next != step) || (step == IDLE_STEP) || !auto_en) begin
            hold_cnt_next = '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt_next = hold_cnt + 1'b1;
        end
    end

    always_comb begin
        ctrl_word = STEP_TABLE[int'(step)*CW_W +: CW_W];
        selA      = ctrl_word[ALU_OP_W + SEL_A_OFS];
        aluOp     = ctrl_word[ALUOP_LSB +: ALU_OP_W];
        // In pulse mode the write enables only fire in the first cycle of a step.
        wrA       = ctrl_word[ALU_OP_W + WR_A_OFS] & (first | (WR_PULSE == 0));
        wrB       = ctrl_word[ALU_OP_W + WR_B_OFS] & (first | (WR_PULSE == 0));
    end

    assign busy       = (step != IDLE_STEP);
    assign prStateLed = step;
    assign nxStateLed = step_next;

endmodule

// File: tb/tb_seq_controle.sv
// tb/tb_seq_controle.sv - directed self-checking bench for seq_controle
module tb_seq_controle;

    logic clock = 1'b1;
    logic reset = 1'b1;
    logic dv = 1'b1;
    logic auto_en = 1'b0;
    logic abort = 1'b0;

    logic       d_selA, d_wrA, d_wrB, d_busy, d_done;
    logic [1:0] d_aluOp;
    logic [2:0] d_pr, d_nx;

    logic       l_selA, l_wrA, l_wrB, l_busy, l_done;
    logic [1:0] l_aluOp;
    logic [2:0] l_pr, l_nx;

    logic       s_selA, s_wrA, s_wrB, s_busy, s_done;
    logic [2:0] s_aluOp;
    logic [1:0] s_pr, s_nx;

    int n_cmp = 0;
    int n_bad = 0;

    logic       exp_sel [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_wra [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       exp_wrb [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] exp_alu [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    always #5 clock = ~clock;

    seq_controle u_def (
        .clock(clock), .reset(reset), .dv(dv), .auto_en(auto_en), .abort(abort),
        .selA(d_selA), .wrA(d_wrA), .wrB(d_wrB), .aluOp(d_aluOp),
        .busy(d_busy), .done(d_done), .prStateLed(d_pr), .nxStateLed(d_nx)
    );

    seq_controle #(.WR_PULSE(0)) u_lvl (
        .clock(clock), .reset(reset), .dv(dv), .auto_en(auto_en), .abort(abort),
        .selA(l_selA), .wrA(l_wrA), .wrB(l_wrB), .aluOp(l_aluOp),
        .busy(l_busy), .done(l_done), .prStateLed(l_pr), .nxStateLed(l_nx)
    );

    // step0 idle, step1 {sel,wrA}=11 aluOp 101, step2 wrB aluOp 011
    seq_controle #(
        .N_STEPS(3), .ALU_OP_W(3),
        .STEP_TABLE(18'b001011_110101_000000)
    ) u_s3 (
        .clock(clock), .reset(reset), .dv(dv), .auto_en(auto_en), .abort(abort),
        .selA(s_selA), .wrA(s_wrA), .wrB(s_wrB), .aluOp(s_aluOp),
        .busy(s_busy), .done(s_done), .prStateLed(s_pr), .nxStateLed(s_nx)
    );

    // Advance past the next active (falling) edge and sample 1 time unit later.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; dv = 1'b0; abort = 1'b0; auto_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic dv_pulse();
        dv = 1'b1; tick();
        dv = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; dv = 1'b1; auto_en = 1'b0; abort = 1'b0;
        tick(); tick();
        n_cmp++; if ({d_pr, d_busy, d_done, d_selA, d_wrA, d_wrB, d_aluOp} !== 10'b0) begin
            n_bad++; $display("FAIL reset_state: got %b want 0", {d_pr, d_busy, d_done, d_selA, d_wrA, d_wrB, d_aluOp});
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if ({d_pr, d_busy, d_wrA, d_wrB} !== 6'b0) begin
                n_bad++; $display("FAIL dv_high_after_reset cyc %0d: got pr=%0d busy=%b wrA=%b wrB=%b want 0", i, d_pr, d_busy, d_wrA, d_wrB);
            end
        end
        dv = 1'b0;
        tick();
    endtask

    task automatic test_manual();
        int e;
        do_reset();
        for (int s = 1; s <= 5; s++) begin
            e = s % 5;
            dv = 1'b1;
            #1;
            n_cmp++; if (d_nx !== 3'(e)) begin
                n_bad++; $display("FAIL manual_nx s%0d: got %0d want %0d", s, d_nx, e);
            end
            tick();
            n_cmp++; if ({d_pr, d_selA, d_wrA, d_wrB, d_aluOp, d_done} !== {3'(e), exp_sel[e], exp_wra[e], exp_wrb[e], exp_alu[e], e == 0}) begin
                n_bad++; $display("FAIL manual_first s%0d: got pr=%0d sel=%b wrA=%b wrB=%b alu=%0d done=%b want pr=%0d sel=%b wrA=%b wrB=%b alu=%0d done=%b",
                    s, d_pr, d_selA, d_wrA, d_wrB, d_aluOp, d_done, e, exp_sel[e], exp_wra[e], exp_wrb[e], exp_alu[e], e == 0);
            end
            tick();
            n_cmp++; if ({d_pr, d_selA, d_wrA, d_wrB, d_aluOp, d_done} !== {3'(e), exp_sel[e], 1'b0, 1'b0, exp_alu[e], 1'b0}) begin
                n_bad++; $display("FAIL manual_second s%0d: got pr=%0d sel=%b wrA=%b wrB=%b alu=%0d done=%b want pr=%0d sel=%b wrA=0 wrB=0 alu=%0d done=0",
                    s, d_pr, d_selA, d_wrA, d_wrB, d_aluOp, d_done, e, exp_sel[e], exp_alu[e]);
            end
            n_cmp++; if ({l_wrA, l_wrB} !== {exp_wra[e], exp_wrb[e]}) begin
                n_bad++; $display("FAIL level_wr s%0d: got wrA=%b wrB=%b want wrA=%b wrB=%b", s, l_wrA, l_wrB, exp_wra[e], exp_wrb[e]);
            end
            tick();
            dv = 1'b0;
            tick();
            n_cmp++; if (d_pr !== 3'(e)) begin
                n_bad++; $display("FAIL manual_hold s%0d: got %0d want %0d", s, d_pr, e);
            end
        end
    endtask

    task automatic test_auto();
        do_reset();
        auto_en = 1'b1;
        repeat (12) tick();
        n_cmp++; if (d_pr !== 3'd0) begin
            n_bad++; $display("FAIL auto_idle_wait: got %0d want 0", d_pr);
        end
        dv = 1'b1; tick(); dv = 1'b0;
        n_cmp++; if (d_pr !== 3'd1) begin
            n_bad++; $display("FAIL auto_enter: got %0d want 1", d_pr);
        end
        for (int s = 1; s <= 4; s++) begin
            repeat (7) tick();
            n_cmp++; if (d_pr !== 3'(s)) begin
                n_bad++; $display("FAIL auto_hold s%0d: got %0d want %0d", s, d_pr, s);
            end
            tick();
            n_cmp++; if ({d_pr, d_done} !== {3'((s + 1) % 5), s == 4}) begin
                n_bad++; $display("FAIL auto_step s%0d: got pr=%0d done=%b want pr=%0d done=%b", s, d_pr, d_done, (s + 1) % 5, s == 4);
            end
        end
        repeat (20) tick();
        n_cmp++; if ({d_pr, d_done} !== 4'b0) begin
            n_bad++; $display("FAIL auto_wait_zero: got pr=%0d done=%b want 0", d_pr, d_done);
        end
        auto_en = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        repeat (3) dv_pulse();
        n_cmp++; if (d_pr !== 3'd3) begin
            n_bad++; $display("FAIL abort_setup: got %0d want 3", d_pr);
        end
        auto_en = 1'b1;
        repeat (3) tick();
        dv = 1'b1; abort = 1'b1;
        #1;
        n_cmp++; if (d_nx !== 3'd0) begin
            n_bad++; $display("FAIL abort_nx: got %0d want 0", d_nx);
        end
        tick();
        n_cmp++; if ({d_pr, d_done, d_busy, u_def.hold_cnt} !== {3'd0, 1'b0, 1'b0, 3'd0}) begin
            n_bad++; $display("FAIL abort_result: got pr=%0d done=%b busy=%b hold=%0d want all 0", d_pr, d_done, d_busy, u_def.hold_cnt);
        end
        abort = 1'b0; dv = 1'b0;
        tick();
        auto_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        auto_en = 1'b1;
        dv = 1'b1; tick(); dv = 1'b0;
        repeat (7) tick();
        dv = 1'b1;
        tick();
        n_cmp++; if (d_pr !== 3'd2) begin
            n_bad++; $display("FAIL rise_and_timeout: got %0d want 2", d_pr);
        end
        tick();
        n_cmp++; if (d_pr !== 3'd2) begin
            n_bad++; $display("FAIL rise_and_timeout_hold: got %0d want 2", d_pr);
        end
        dv = 1'b0; auto_en = 1'b0;
        tick();
    endtask

    task automatic test_level_async_reset();
        do_reset();
        repeat (2) dv_pulse();
        dv = 1'b1; tick();
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if ({l_pr, l_wrA, l_aluOp} !== {3'd3, 1'b1, 2'd2}) begin
                n_bad++; $display("FAIL level_step3 cyc %0d: got pr=%0d wrA=%b alu=%0d want pr=3 wrA=1 alu=2", i, l_pr, l_wrA, l_aluOp);
            end
            if (i == 0) dv = 1'b0;
            if (i < 5) tick();
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if ({l_pr, l_busy, l_selA, l_wrA, l_wrB, l_aluOp, l_done} !== 10'b0) begin
            n_bad++; $display("FAIL async_reset: got pr=%0d busy=%b sel=%b wrA=%b wrB=%b alu=%0d done=%b want 0",
                l_pr, l_busy, l_selA, l_wrA, l_wrB, l_aluOp, l_done);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_three_steps();
        do_reset();
        dv_pulse();
        n_cmp++; if ({s_pr, s_selA, s_wrB, s_aluOp} !== {2'd1, 1'b1, 1'b0, 3'b101}) begin
            n_bad++; $display("FAIL s3_step1: got pr=%0d sel=%b wrB=%b alu=%b want pr=1 sel=1 wrB=0 alu=101", s_pr, s_selA, s_wrB, s_aluOp);
        end
        dv = 1'b1; tick();
        n_cmp++; if ({s_pr, s_selA, s_wrA, s_wrB, s_aluOp} !== {2'd2, 1'b0, 1'b0, 1'b1, 3'b011}) begin
            n_bad++; $display("FAIL s3_step2: got pr=%0d sel=%b wrA=%b wrB=%b alu=%b want pr=2 sel=0 wrA=0 wrB=1 alu=011", s_pr, s_selA, s_wrA, s_wrB, s_aluOp);
        end
        dv = 1'b0; tick();
        dv = 1'b1;
        #1;
        n_cmp++; if (s_nx !== 2'd0) begin
            n_bad++; $display("FAIL s3_nx_wrap: got %0d want 0", s_nx);
        end
        tick();
        n_cmp++; if ({s_pr, s_done, s_aluOp} !== {2'd0, 1'b1, 3'b000}) begin
            n_bad++; $display("FAIL s3_wrap: got pr=%0d done=%b alu=%b want pr=0 done=1 alu=000", s_pr, s_done, s_aluOp);
        end
        tick();
        n_cmp++; if (s_done !== 1'b0) begin
            n_bad++; $display("FAIL s3_done_once: got %b want 0", s_done);
        end
        dv = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto();
        test_abort();
        test_back_to_back();
        test_level_async_reset();
        test_three_steps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
